axi2mem_ctrl_fsm: RTL
=====================

// Module: axi2mem_ctrl_fsm
// PURPOSE
//  Single-port memory controller for the axi2mem response model. Accepts AXI4 AR
//  and AW/W bursts from one axi_if slave port and arbitrates between reads and
//  writes, one transaction at a time. Sequences each burst beat-by-beat onto a
//  1-cycle-latency, always-ready SRAM-style port and returns R beats and the B response.
// PARAMETERS
//  WD_ADDR  64  AXI/memory byte-address width
//  WD_DATA  64  data width; WD_STRB = WD_DATA/8
//  WD_ID    4   AXI ID width
//  WD_USER  1   AXI user width (user outputs tied 0)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  ar_valid/ar_ready  in/out 1  AR handshake
//  ar_addr,ar_len,ar_size,ar_burst,ar_id  in  WD_ADDR,8,3,2,WD_ID  read request fields
//  aw_valid/aw_ready  in/out 1  AW handshake
//  aw_addr,aw_len,aw_size,aw_burst,aw_id,aw_atop  in  WD_ADDR,8,3,2,WD_ID,6  write request
//  w_valid/w_ready    in/out 1  W handshake
//  w_data,w_strb,w_last  in  WD_DATA,WD_STRB,1  write beat
//  b_valid/b_ready    out/in 1  B handshake; b_id out WD_ID; b_resp out 2; b_user out WD_USER
//  r_valid/r_ready    out/in 1  R handshake; r_data out WD_DATA; r_id out WD_ID
//  r_resp,r_last,r_user  out  2,1,WD_USER  read beat status
//  mem_req    out  1        memory access strobe (memory always accepts)
//  mem_we     out  1        1 = write, 0 = read
//  mem_addr   out  WD_ADDR  byte address of current beat
//  mem_wdata  out  WD_DATA  write data (= w_data)
//  mem_be     out  WD_STRB  byte enables (= w_strb)
//  mem_rdata  in   WD_DATA  read data, valid the cycle after a read mem_req
// BEHAVIOUR
//  Reset: state=IDLE; all *_ready, *_valid, mem_req, mem_we = 0; r_data/ids/addr
//   regs = 0; last_grant = WR (first contested grant goes to read). Reset mid-burst
//   aborts the transaction silently; no partial B or R is emitted.
//  FSM states: IDLE, RD_REQ, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
//  IDLE: ar_ready = sel_rd, aw_ready = sel_wr (combinational). If both valid, pick
//   the side != last_grant; else the valid one. On handshake, latch addr/len/size/
//   burst/id, clear beat_cnt, update last_grant -> RD_REQ or WR_DATA.
//  RD_REQ: mem_req=1, mem_we=0 for exactly one cycle -> RD_WAIT.
//  RD_WAIT: register mem_rdata -> RD_DATA.
//  RD_DATA: r_valid=1, r_resp=OKAY, r_last=(beat_cnt==len); fields held stable
//   until r_ready. On handshake: if last -> IDLE, else advance addr, beat_cnt++ -> RD_REQ.
//   AR handshake at cycle T => mem_req at T+1, first r_valid at T+3.
//  WR_DATA: w_ready=1; mem_req = w_valid & ~err, mem_we=1, same cycle (combinational
//   from w_data/w_strb). Each W handshake advances addr and beat_cnt. Beat with
//   beat_cnt==len ends burst -> WR_RESP. w_last != (beat_cnt==len) sets err.
//  aw_atop != 0: err set at AW accept; W beats still drained, no memory write.
//  WR_RESP: b_valid=1, b_id=latched id, b_resp = err ? SLVERR(2'b10) : OKAY(2'b00);
//   held until b_ready -> IDLE, err cleared.
//  Address update: FIXED keeps addr; INCR and WRAP add (1<<size), modulo 2^WD_ADDR
//   (WRAP treated as INCR). size > log2(WD_STRB) is not checked.
//  Only one transaction in flight; the other channel's ready stays 0 until IDLE.
//  r_user, b_user = 0.
// TESTING
//  Single read: AR addr=0x100,len=0,size=3,id=5 -> mem_req@T+1 addr 0x100;
//   r_valid@T+3, r_id=5, r_last=1, r_resp=0.
//  INCR write len=3 size=3 @0x200 -> mem writes 0x200,0x208,0x210,0x218;
//   then B id, resp=OKAY.
//  Simultaneous AR and AW after reset -> read granted first; next contested grant
//   goes to write (alternation over 4 pairs).
//  r_ready held 0 for 5 cycles on beat 1 of a 4-beat read -> r_data stable;
//   no extra mem_req; all beats in order.
//  aw_atop=6'h20 len=1 -> 2 W beats accepted, mem_req never 1, b_resp=2'b10.
//  rst pulsed during WR_DATA beat 2 -> outputs 0 next edge; new AR serviced normally.

Source files
------------

// File: rtl/axi2mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi2mem_if : AXI4 bus bundle between the traffic master and axi2mem         |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface axi2mem_if #(
   parameter int WD_ADDR = 64,
   parameter int WD_DATA = 64,
   parameter int WD_ID   = 4,
   parameter int WD_USER = 1
) ();
   logic                   ar_valid;
   logic                   ar_ready;
   logic [WD_ADDR-1:0]     ar_addr;
   logic [7:0]             ar_len;
   logic [2:0]             ar_size;
   logic [1:0]             ar_burst;
   logic [WD_ID-1:0]       ar_id;

   logic                   aw_valid;
   logic                   aw_ready;
   logic [WD_ADDR-1:0]     aw_addr;
   logic [7:0]             aw_len;
   logic [2:0]             aw_size;
   logic [1:0]             aw_burst;
   logic [WD_ID-1:0]       aw_id;
   logic [5:0]             aw_atop;

   logic                   w_valid;
   logic                   w_ready;
   logic [WD_DATA-1:0]     w_data;
   logic [WD_DATA/8-1:0]   w_strb;
   logic                   w_last;

   logic                   b_valid;
   logic                   b_ready;
   logic [WD_ID-1:0]       b_id;
   logic [1:0]             b_resp;
   logic [WD_USER-1:0]     b_user;

   logic                   r_valid;
   logic                   r_ready;
   logic [WD_DATA-1:0]     r_data;
   logic [WD_ID-1:0]       r_id;
   logic [1:0]             r_resp;
   logic                   r_last;
   logic [WD_USER-1:0]     r_user;

   modport master (
      output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
      input  ar_ready,
      output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_atop,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_id, b_resp, b_user,
      output b_ready,
      input  r_valid, r_data, r_id, r_resp, r_last, r_user,
      output r_ready
   );

   modport slave (
      input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
      output ar_ready,
      input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_atop,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_id, b_resp, b_user,
      input  b_ready,
      output r_valid, r_data, r_id, r_resp, r_last, r_user,
      input  r_ready
   );
endinterface
`default_nettype wire

// File: rtl/axi2mem_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi2mem_ctrl_fsm : one-at-a-time AXI4 burst sequencer onto an SRAM port     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module axi2mem_ctrl_fsm #(
   parameter int WD_ADDR = 64,
   parameter int WD_DATA = 64,
   parameter int WD_ID   = 4,
   parameter int WD_USER = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   axi2mem_if.slave             axi,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [WD_ADDR-1:0]   mem_addr,
   output logic [WD_DATA-1:0]   mem_wdata,
   output logic [WD_DATA/8-1:0] mem_be,
   input  logic [WD_DATA-1:0]   mem_rdata
);
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [WD_ADDR-1:0] ADDR_ONE = {{(WD_ADDR-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_RD_DATA = 3'd3,
      S_WR_DATA = 3'd4,
      S_WR_RESP = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [WD_ADDR-1:0]   addr_q, addr_d, next_addr;
   logic [7:0]           len_q, len_d, beat_cnt_q, beat_cnt_d;
   logic [2:0]           size_q, size_d;
   logic [1:0]           burst_q, burst_d;
   logic [WD_ID-1:0]     id_q, id_d;
   logic [WD_DATA-1:0]   rdata_q, rdata_d;
   logic                 last_wr_q, last_wr_d;
   logic                 err_q, err_d;
   logic                 sel_rd, sel_wr, last_beat;
   logic                 ar_ready, aw_ready, w_ready, r_valid, b_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         id_q       <= '0;
         rdata_q    <= '0;
         last_wr_q  <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         id_q       <= id_d;
         rdata_q    <= rdata_d;
         last_wr_q  <= last_wr_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      size_d     = size_q;
      burst_d    = burst_q;
      id_d       = id_q;
      rdata_d    = rdata_q;
      last_wr_d  = last_wr_q;
      err_d      = err_q;
      ar_ready   = 1'b0;
      aw_ready   = 1'b0;
      w_ready    = 1'b0;
      r_valid    = 1'b0;
      b_valid    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;

      // Contested requests go to the side that did not win last time.
      sel_rd    = axi.ar_valid & (~axi.aw_valid | last_wr_q);
      sel_wr    = axi.aw_valid & (~axi.ar_valid | ~last_wr_q);
      last_beat = (beat_cnt_q == len_q);
      // WRAP bursts step like INCR; FIXED stays on one address.
      next_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + (ADDR_ONE << size_q);

      case (state_q)
         S_IDLE: begin
            ar_ready = sel_rd;
            aw_ready = sel_wr;
            if (sel_rd) begin
               addr_d     = axi.ar_addr;
               len_d      = axi.ar_len;
               size_d     = axi.ar_size;
               burst_d    = axi.ar_burst;
               id_d       = axi.ar_id;
               beat_cnt_d = '0;
               last_wr_d  = 1'b0;
               state_d    = S_RD_REQ;
            end else if (sel_wr) begin
               addr_d     = axi.aw_addr;
               len_d      = axi.aw_len;
               size_d     = axi.aw_size;
               burst_d    = axi.aw_burst;
               id_d       = axi.aw_id;
               beat_cnt_d = '0;
               last_wr_d  = 1'b1;
               err_d      = (axi.aw_atop != 6'd0);
               state_d    = S_WR_DATA;
            end
         end
         S_RD_REQ: begin
            mem_req = 1'b1;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            rdata_d = mem_rdata;
            state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            r_valid = 1'b1;
            if (axi.r_ready) begin
               if (last_beat) begin
                  state_d = S_IDLE;
               end else begin
                  addr_d     = next_addr;
                  beat_cnt_d = beat_cnt_q + 8'd1;
                  state_d    = S_RD_REQ;
               end
            end
         end
         S_WR_DATA: begin
            w_ready = 1'b1;
            mem_we  = 1'b1;
            // Once an error is flagged the rest of the burst is drained unwritten.
            mem_req = axi.w_valid & ~err_q;
            if (axi.w_valid) begin
               if (axi.w_last != last_beat) begin
                  err_d = 1'b1;
               end
               addr_d     = next_addr;
               beat_cnt_d = beat_cnt_q + 8'd1;
               if (last_beat) begin
                  state_d = S_WR_RESP;
               end
            end
         end
         S_WR_RESP: begin
            b_valid = 1'b1;
            if (axi.b_ready) begin
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign axi.ar_ready = ar_ready;
   assign axi.aw_ready = aw_ready;
   assign axi.w_ready  = w_ready;
   assign axi.r_valid  = r_valid;
   assign axi.r_data   = rdata_q;
   assign axi.r_id     = id_q;
   assign axi.r_resp   = RESP_OKAY;
   assign axi.r_last   = last_beat;
   assign axi.r_user   = {WD_USER{1'b0}};
   assign axi.b_valid  = b_valid;
   assign axi.b_id     = id_q;
   assign axi.b_resp   = err_q ? RESP_SLVERR : RESP_OKAY;
   assign axi.b_user   = {WD_USER{1'b0}};

   assign mem_addr  = addr_q;
   assign mem_wdata = axi.w_data;
   assign mem_be    = axi.w_strb;
endmodule
`default_nettype wire
